timer_nch: RTL and testbench
============================

TIMER_NCH -- requirements
Module: timer_nch

Interface
REQ-001 Parameter CNT_W, default 16, counter/prescaler/compare width in bits.
REQ-002 Parameter NCH, default 4, number of compare/PWM channels (1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  counter enable (start trigger in one-pulse mode).
REQ-006 mode  input  2  00 up, 01 down, 10 center-aligned, 11 one-pulse up.
REQ-007 psc  input  CNT_W  prescaler; counter ticks every psc+1 clocks.
REQ-008 arr  input  CNT_W  auto-reload (period top) value.
REQ-009 ccr  input  NCH*CNT_W  compare values; channel i at bits [i*CNT_W +: CNT_W].
REQ-010 pol  input  NCH  per-channel output polarity; 1 inverts.
REQ-011 cnt  output  CNT_W  current counter value.
REQ-012 dir  output  1  count direction; 0 up, 1 down.
REQ-013 running  output  1  counter is advancing on ticks.
REQ-014 pwm  output  NCH  registered PWM outputs.
REQ-015 upd_irq  output  1  one-cycle pulse on update event.
REQ-016 cc_irq  output  NCH  one-cycle pulse per channel on compare match.

Function
REQ-017 Prescaler counter counts 0..psc while running; tick asserted in the cycle it equals psc, then it reloads 0; psc=0 gives a tick every clock.
REQ-018 Modes 00-10: running equals en; en low freezes cnt, dir and prescaler counter; pwm keeps tracking frozen cnt.
REQ-019 Mode 11: running sets on en 0->1 edge only, clears on the update event; cnt returns to 0; en held high never restarts.
REQ-020 Up: on tick cnt increments; tick with cnt>=arr loads 0 and raises upd_irq (arr lowered below cnt wraps on next tick).
REQ-021 Down: dir=1; tick with cnt==0 loads arr and raises upd_irq; cnt>arr on tick loads arr.
REQ-022 Center: up to arr, then dir=1 and down to 0, then dir=0; upd_irq at tick reaching 0 while dir=1; period 2*arr ticks; arr=0 holds cnt=0 with upd_irq every tick.
REQ-023 pwm[i] registered = (cnt < ccr_i) XOR pol[i], one cycle after cnt; ccr_i=0 gives 0% active, ccr_i>arr gives 100% active.
REQ-024 cc_irq[i] pulses the cycle after a tick makes cnt equal ccr_i; simultaneous update and compare events both pulse.
REQ-025 Mode change takes effect at the next tick; dir forced to mode's start direction when leaving center mode.
REQ-026 All comparisons unsigned, CNT_W bits; increments never exceed arr.

Reset
REQ-027 reset asserted clears immediately: cnt=0, dir=0, running=0, pwm=0, upd_irq=0, cc_irq=0, prescaler counter 0, shadow registers 0.
REQ-028 Reset mid-period abandons the cycle; first tick after release resumes from cnt=0.

Configuration
REQ-029 Macro TIM_PRELOAD_EN defined: psc, arr and ccr are copied to shadow registers every clock while running=0 and only on the update event while running=1; counting and compares use shadows.
REQ-030 TIM_PRELOAD_EN undefined: no shadow registers; psc, arr, ccr used live every cycle.

Verification
REQ-031 Up, psc=0, arr=9, ccr0=3, pol=0 -> cnt 0..9 repeating, pwm[0] high 3 of 10 clocks, upd_irq every 10 clocks, cc_irq[0] once per period.
REQ-032 Up, psc=2, arr=3 -> cnt changes every 3 clocks, upd_irq every 12 clocks.
REQ-033 Center, psc=0, arr=4 -> cnt 0,1,2,3,4,3,2,1,0,1..., dir=1 on descent, upd_irq every 8 ticks at cnt=0.
REQ-034 One-pulse, arr=5, en 0->1 then held -> cnt 0..5 once, single upd_irq, running falls, cnt stays 0.
REQ-035 ccr1=0 and ccr2=arr+1, pol[2]=1 -> pwm[1] always 0, pwm[2] always 0; pol[2]=0 -> pwm[2] always 1.
REQ-036 Reset pulsed at cnt=6 -> all outputs 0 same cycle; with TIM_PRELOAD_EN, arr 9->4 at cnt=2 keeps period 10 then 5; without it wraps after cnt=4.

Source files
------------

// File: rtl/timer_nch_if.sv
// Bundles the control inputs and status outputs of timer_nch into one port.
// The master side drives the configuration; the slave side is the timer itself.
interface timer_nch_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NCH   = 4
);
    logic                 en;
    logic [1:0]           mode;
    logic [CNT_W-1:0]     psc;
    logic [CNT_W-1:0]     arr;
    logic [NCH*CNT_W-1:0] ccr;
    logic [NCH-1:0]       pol;
    logic [CNT_W-1:0]     cnt;
    logic                 dir;
    logic                 running;
    logic [NCH-1:0]       pwm;
    logic                 upd_irq;
    logic [NCH-1:0]       cc_irq;

    modport master (
        output en, mode, psc, arr, ccr, pol,
        input  cnt, dir, running, pwm, upd_irq, cc_irq
    );

    modport slave (
        input  en, mode, psc, arr, ccr, pol,
        output cnt, dir, running, pwm, upd_irq, cc_irq
    );
endinterface

// File: rtl/timer_nch.sv
// Prescaled up/down/center/one-pulse timer with NCH compare/PWM channels.
// Define TIM_PRELOAD_EN to buffer psc/arr/ccr in shadow registers loaded at update events.
module timer_nch #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned NCH   = 4
) (
    input logic        clk,
    input logic        reset,
    timer_nch_if.slave bus
);
    typedef enum logic [1:0] {
        ModeUp       = 2'b00,
        ModeDown     = 2'b01,
        ModeCenter   = 2'b10,
        ModeOnePulse = 2'b11
    } mode_e;

    mode_e                mode;
    logic [CNT_W-1:0]     psc_e, arr_e;
    logic [NCH*CNT_W-1:0] ccr_e;
    logic [CNT_W-1:0]     psc_cnt_q, cnt_q, cnt_d, cnt_inc;
    logic                 dir_q, dir_d;
    logic                 op_run_q, en_q;
    logic                 running, tick, upd_evt;
    logic [NCH-1:0]       pwm_q, pwm_d, cc_q, cc_d;
    logic                 upd_q;

    assign mode    = mode_e'(bus.mode);
    // Reset gates the combinational enable path so running reads 0 while reset is held.
    assign running = !reset && ((mode == ModeOnePulse) ? op_run_q : bus.en);
    assign tick    = running && (psc_cnt_q >= psc_e);
    assign cnt_inc = cnt_q + 1'b1;

`ifdef TIM_PRELOAD_EN
    logic [CNT_W-1:0]     psc_q, arr_q;
    logic [NCH*CNT_W-1:0] ccr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= '0;
            arr_q <= '0;
            ccr_q <= '0;
        end else if (!running || upd_evt) begin
            psc_q <= bus.psc;
            arr_q <= bus.arr;
            ccr_q <= bus.ccr;
        end
    end

    assign psc_e = psc_q;
    assign arr_e = arr_q;
    assign ccr_e = ccr_q;
`else
    assign psc_e = bus.psc;
    assign arr_e = bus.arr;
    assign ccr_e = bus.ccr;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        upd_evt = 1'b0;
        if (tick) begin
            unique case (mode)
                ModeUp, ModeOnePulse: begin
                    dir_d = 1'b0;
                    if (cnt_q >= arr_e) begin
                        cnt_d   = '0;
                        upd_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ModeDown: begin
                    dir_d = 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d   = arr_e;
                        upd_evt = 1'b1;
                    end else if (cnt_q > arr_e) begin
                        cnt_d = arr_e;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ModeCenter: begin
                    if (arr_e == '0) begin
                        cnt_d   = '0;
                        dir_d   = 1'b0;
                        upd_evt = 1'b1;
                    end else if (!dir_q) begin
                        // Direction flips on the tick that reaches the top.
                        if (cnt_q >= arr_e) begin
                            cnt_d = arr_e;
                            dir_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                            dir_d = (cnt_inc == arr_e);
                        end
                    end else if (cnt_q > arr_e) begin
                        cnt_d = arr_e;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        dir_d   = 1'b0;
                        upd_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        logic [CNT_W-1:0] ch_ccr;
        ch_ccr = '0;
        pwm_d  = '0;
        cc_d   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_ccr   = ccr_e[i*CNT_W +: CNT_W];
            pwm_d[i] = (cnt_q < ch_ccr) ^ bus.pol[i];
            cc_d[i]  = tick && (cnt_d == ch_ccr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_cnt_q <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            op_run_q  <= 1'b0;
            en_q      <= 1'b0;
            pwm_q     <= '0;
            upd_q     <= 1'b0;
            cc_q      <= '0;
        end else begin
            en_q <= bus.en;
            if (running) begin
                psc_cnt_q <= tick ? '0 : psc_cnt_q + 1'b1;
            end
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pwm_q <= pwm_d;
            upd_q <= upd_evt;
            cc_q  <= cc_d;
            if (mode != ModeOnePulse || upd_evt) begin
                op_run_q <= 1'b0;
            end else if (bus.en && !en_q) begin
                op_run_q <= 1'b1;
            end
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.dir     = dir_q;
    assign bus.running = running;
    assign bus.pwm     = pwm_q;
    assign bus.upd_irq = upd_q;
    assign bus.cc_irq  = cc_q;
endmodule

// File: tb/tb_timer_nch.sv
// Randomized scoreboard bench for timer_nch against a closed-form model of the count sequence.
module tb_timer_nch;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned NCH   = 4;

    logic clk = 1'b0;
    logic reset;

    timer_nch_if #(.CNT_W(CNT_W), .NCH(NCH)) bus ();

    timer_nch #(.CNT_W(CNT_W), .NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             dir;
        logic             running;
        logic [NCH-1:0]   pwm;
        logic             upd;
        logic [NCH-1:0]   cc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Segment configuration and model state
    int             c_mode, c_psc, c_arr;
    int             c_ccr[NCH];
    logic [NCH-1:0] c_pol;
    int             m_ph, m_k;
    bit             m_op_run, m_en_prev, m_first;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_reset(input string name);
        check(name, 64'({bus.cnt, bus.dir, bus.running, bus.pwm, bus.upd_irq, bus.cc_irq}),
              64'd0);
    endtask

    // Counter value, direction and update flag after k ticks from the start of a run.
    function automatic void cnt_of(input int k, output int c, output bit d, output bit u);
        int r, p;
        c = 0; d = 0; u = 0;
        case (c_mode)
            1: if (k > 0) begin
                r = (k - 1) % (c_arr + 1);
                c = c_arr - r;
                d = 1;
                u = (r == 0);
            end
            2: if (c_arr == 0) begin
                u = (k > 0);
            end else begin
                p = k % (2 * c_arr);
                c = (p <= c_arr) ? p : 2 * c_arr - p;
                d = (p >= c_arr);
                u = (k > 0) && (p == 0);
            end
            default: begin
                c = k % (c_arr + 1);
                u = (k > 0) && (c == 0);
            end
        endcase
    endfunction

    task automatic model_step();
        bit   run, tick, d0, d1, u0, u1;
        int   c0, c1, ccr_now;
        exp_t e;
        run  = (c_mode == 3) ? m_op_run : bus.en;
        tick = run && (m_ph == c_psc);
        cnt_of(m_k, c0, d0, u0);
        for (int i = 0; i < NCH; i++) begin
            ccr_now = c_ccr[i];
`ifdef TIM_PRELOAD_EN
            if (m_first) ccr_now = 0;
`endif
            e.pwm[i] = (c0 < ccr_now) ^ c_pol[i];
        end
        m_first = 0;
        if (run) m_ph = tick ? 0 : m_ph + 1;
        e.upd = 1'b0;
        c1 = c0;
        d1 = d0;
        if (tick) begin
            m_k++;
            cnt_of(m_k, c1, d1, u1);
            e.upd = u1;
        end
        e.cnt = CNT_W'(c1);
        e.dir = d1;
        for (int i = 0; i < NCH; i++) e.cc[i] = tick && (c1 == c_ccr[i]);
        if (c_mode == 3) begin
            if (e.upd) begin
                m_op_run = 0;
                m_k      = 0;
            end else if (bus.en && !m_en_prev && !m_op_run) begin
                m_op_run = 1;
            end
        end
        m_en_prev = bus.en;
        e.running = (c_mode == 3) ? m_op_run : bus.en;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.cnt, bus.dir, bus.running, bus.pwm, bus.upd_irq, bus.cc_irq} ===
                    {e.cnt, e.dir, e.running, e.pwm, e.upd, e.cc}) begin
                    n_pass++;
                end else begin
                    $display("FAIL scoreboard @%0t mode %0d: cnt %0d exp %0d, dir %0b exp %0b, running %0b exp %0b, pwm %b exp %b, upd_irq %0b exp %0b, cc_irq %b exp %b",
                             $time, c_mode, bus.cnt, e.cnt, bus.dir, e.dir, bus.running,
                             e.running, bus.pwm, e.pwm, bus.upd_irq, e.upd, bus.cc_irq, e.cc);
                end
            end
        end
    end

    task automatic set_cfg(input int mode, input int psc, input int arr, input int cc0,
                           input int cc1, input int cc2, input int cc3, input logic [3:0] pol);
        c_mode   = mode;
        c_psc    = psc;
        c_arr    = arr;
        c_ccr[0] = cc0;
        c_ccr[1] = cc1;
        c_ccr[2] = cc2;
        c_ccr[3] = cc3;
        c_pol    = pol;
    endtask

    task automatic drive_cfg();
        bus.mode = 2'(c_mode);
        bus.psc  = CNT_W'(c_psc);
        bus.arr  = CNT_W'(c_arr);
        for (int i = 0; i < NCH; i++) bus.ccr[i*CNT_W +: CNT_W] = CNT_W'(c_ccr[i]);
        bus.pol = c_pol;
    endtask

    task automatic next_en(input bit en_rand);
        if (!en_rand) bus.en = 1'b1;
        else if (c_mode == 3) begin
            if ($urandom_range(0, 7) == 0) bus.en = !bus.en;
        end else bus.en = ($urandom_range(0, 3) != 0);
    endtask

    // Pulse reset (checking the asynchronous clear) and release with the current config.
    task automatic start_seg();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset("reset_clear");
        @(posedge clk);
        #2;
        drive_cfg();
        bus.en    = 1'b0;
        reset     = 1'b0;
        m_ph      = 0;
        m_k       = 0;
        m_op_run  = 0;
        m_en_prev = 0;
        m_first   = 1;
        model_step();
    endtask

    task automatic run_seg(input int ncyc, input bit en_rand, input int stop_at);
        bit hit;
        start_seg();
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            #2;
            next_en(en_rand);
            model_step();
        end
        if (stop_at >= 0) begin
            hit = 0;
            for (int n = 0; n < 64 && !hit; n++) begin
                @(posedge clk);
                #2;
                if (bus.cnt == CNT_W'(stop_at)) hit = 1;
                else begin
                    next_en(en_rand);
                    model_step();
                end
            end
            check("stop_reached", 64'(hit), 64'd1);
            if (hit) begin
                reset = 1'b1;
                #1;
                check_reset("reset_mid_period");
            end
        end
    endtask

    // Lowering arr mid-period: live arr wraps early, shadowed arr finishes the old period.
    task automatic preload_test();
        bit hit;
        int v, a;
        set_cfg(0, 0, 9, 3, 0, 0, 0, 4'b0000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        drive_cfg();
        bus.en = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        #2;
        bus.en = 1'b1;
        hit    = 0;
        for (int n = 0; n < 30 && !hit; n++) begin
            @(posedge clk);
            #2;
            if (bus.cnt == CNT_W'(2)) hit = 1;
        end
        check("preload_reach_2", 64'(hit), 64'd1);
        if (hit) begin
            bus.arr = CNT_W'(4);
            v = 2;
`ifdef TIM_PRELOAD_EN
            a = 9;
`else
            a = 4;
`endif
            for (int n = 0; n < 14; n++) begin
                if (v >= a) begin
                    v = 0;
                    a = 4;
                end else v++;
                @(posedge clk);
                #1;
                check("arr_change_cnt", 64'(bus.cnt), 64'(v));
            end
        end
    endtask

    initial begin : stimulus
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.mode = '0;
        bus.psc  = '0;
        bus.arr  = '0;
        bus.ccr  = '0;
        bus.pol  = '0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_initial");

        set_cfg(0, 0, 9, 3, 0, 10, 5, 4'b0000);  // ccr1=0 never active, ccr2=arr+1 always
        run_seg(30, 0, 6);
        set_cfg(0, 2, 3, 1, 2, 4, 0, 4'b0100);
        run_seg(40, 0, -1);
        set_cfg(2, 0, 4, 2, 0, 4, 1, 4'b0010);
        run_seg(30, 0, -1);
        set_cfg(3, 0, 5, 3, 5, 0, 6, 4'b0000);
        run_seg(20, 0, -1);
        set_cfg(1, 1, 6, 2, 6, 0, 7, 4'b1001);
        run_seg(30, 0, -1);
        set_cfg(2, 0, 0, 0, 1, 0, 0, 4'b0000);
        run_seg(8, 0, -1);
        set_cfg(0, 1, 0, 0, 1, 0, 0, 4'b1000);
        run_seg(8, 0, -1);

        preload_test();

        for (int s = 0; s < 40; s++) begin
            c_mode = $urandom_range(0, 3);
            c_psc  = $urandom_range(0, 3);
            c_arr  = $urandom_range(0, 12);
            for (int i = 0; i < NCH; i++) c_ccr[i] = $urandom_range(0, c_arr + 1);
            c_pol = 4'($urandom_range(0, 15));
            run_seg($urandom_range(20, 80), 1, -1);
        end

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
